// File: rtl/ahb_lite_master_bridge.sv
// ahb_lite_master_bridge
//   Converts the PicoRV32 native memory interface (mem_valid/mem_ready) into
//   single, non-burst AHB-Lite transfers. One transfer is outstanding at a time
//   and all bus-facing and CPU-facing outputs are registered.
//
//   Optional feature macro: AHB_MST_ERR_TRAP_EN
//     defined   -> err_irq/err_addr trap the first errored transfer (sticky
//                  until HRESET).
//     undefined -> err_irq/err_addr tied low; errors are visible only as
//                  mem_rdata == ERR_RDATA.
//
// Ports
//   HCLK, HRESET                   clock, synchronous active-high reset
//   mem_valid/instr/addr/wdata/wstrb  CPU request (wstrb == 0 means read)
//   mem_ready, mem_rdata           one-cycle completion pulse and read data
//   HADDR/HTRANS/HWRITE/HSIZE/HBURST/HPROT/HWDATA  AHB-Lite master outputs
//   HREADY/HRESP/HRDATA            AHB-Lite slave-mux response
//   err_irq, err_addr              sticky bus-error flag and first error address
module ahb_lite_master_bridge #(
    parameter int unsigned AW        = 32,
    parameter logic [31:0] ERR_RDATA = 32'h0000_0000
) (
    input  logic          HCLK,
    input  logic          HRESET,
    input  logic          mem_valid,
    input  logic          mem_instr,
    input  logic [AW-1:0] mem_addr,
    input  logic [31:0]   mem_wdata,
    input  logic [3:0]    mem_wstrb,
    output logic          mem_ready,
    output logic [31:0]   mem_rdata,
    output logic [AW-1:0] HADDR,
    output logic [1:0]    HTRANS,
    output logic          HWRITE,
    output logic [2:0]    HSIZE,
    output logic [2:0]    HBURST,
    output logic [3:0]    HPROT,
    output logic [31:0]   HWDATA,
    input  logic          HREADY,
    input  logic          HRESP,
    input  logic [31:0]   HRDATA,
    output logic          err_irq,
    output logic [AW-1:0] err_addr
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_DONE
    } state_t;

    localparam logic [1:0] TR_IDLE   = 2'b00;
    localparam logic [1:0] TR_NONSEQ = 2'b10;

    state_t        state_q, state_d;
    logic [AW-1:0] haddr_q, haddr_d;
    logic [1:0]    htrans_q, htrans_d;
    logic          hwrite_q, hwrite_d;
    logic [2:0]    hsize_q, hsize_d;
    logic [3:0]    hprot_q, hprot_d;
    logic [31:0]   hwdata_q, hwdata_d;
    logic          ready_q, ready_d;
    logic [31:0]   rdata_q, rdata_d;

    // The byte offset comes from the strobes, never from the CPU address LSBs.
    logic          unused_addr_lsb;
    assign unused_addr_lsb = ^mem_addr[1:0];

    logic [2:0]    req_size;
    logic [1:0]    req_off;

    always_comb begin
        req_size = 3'b010;
        req_off  = 2'b00;
        unique case (mem_wstrb)
            4'b0011: begin req_size = 3'b001; req_off = 2'b00; end
            4'b1100: begin req_size = 3'b001; req_off = 2'b10; end
            4'b0001: begin req_size = 3'b000; req_off = 2'b00; end
            4'b0010: begin req_size = 3'b000; req_off = 2'b01; end
            4'b0100: begin req_size = 3'b000; req_off = 2'b10; end
            4'b1000: begin req_size = 3'b000; req_off = 2'b11; end
            default: begin req_size = 3'b010; req_off = 2'b00; end
        endcase
    end

    always_comb begin
        state_d  = state_q;
        haddr_d  = haddr_q;
        htrans_d = htrans_q;
        hwrite_d = hwrite_q;
        hsize_d  = hsize_q;
        hprot_d  = hprot_q;
        hwdata_d = hwdata_q;
        ready_d  = 1'b0;
        rdata_d  = rdata_q;
        unique case (state_q)
            S_IDLE: begin
                if (mem_valid && !ready_q) begin
                    haddr_d  = {mem_addr[AW-1:2], req_off};
                    hwrite_d = |mem_wstrb;
                    hsize_d  = req_size;
                    hprot_d  = {2'b00, 1'b1, ~mem_instr};
                    htrans_d = TR_NONSEQ;
                    state_d  = S_ADDR;
                end
            end
            S_ADDR: begin
                if (HREADY) begin
                    htrans_d = TR_IDLE;
                    hwdata_d = mem_wdata;
                    state_d  = S_DATA;
                end
            end
            S_DATA: begin
                if (HREADY) begin
                    rdata_d = HRESP ? ERR_RDATA : HRDATA;
                    ready_d = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q  <= S_IDLE;
            haddr_q  <= '0;
            htrans_q <= TR_IDLE;
            hwrite_q <= 1'b0;
            hsize_q  <= 3'b010;
            hprot_q  <= 4'b0011;
            hwdata_q <= '0;
            ready_q  <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            haddr_q  <= haddr_d;
            htrans_q <= htrans_d;
            hwrite_q <= hwrite_d;
            hsize_q  <= hsize_d;
            hprot_q  <= hprot_d;
            hwdata_q <= hwdata_d;
            ready_q  <= ready_d;
            rdata_q  <= rdata_d;
        end
    end

    assign HADDR     = haddr_q;
    assign HTRANS    = htrans_q;
    assign HWRITE    = hwrite_q;
    assign HSIZE     = hsize_q;
    assign HBURST    = 3'b000;
    assign HPROT     = hprot_q;
    assign HWDATA    = hwdata_q;
    assign mem_ready = ready_q;
    assign mem_rdata = rdata_q;

`ifdef AHB_MST_ERR_TRAP_EN
    logic          err_irq_q, err_irq_d;
    logic [AW-1:0] err_addr_q, err_addr_d;

    // Only the first error is latched; HADDR is still held during the data phase.
    always_comb begin
        err_irq_d  = err_irq_q;
        err_addr_d = err_addr_q;
        if (state_q == S_DATA && HREADY && HRESP && !err_irq_q) begin
            err_irq_d  = 1'b1;
            err_addr_d = haddr_q;
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            err_irq_q  <= 1'b0;
            err_addr_q <= '0;
        end else begin
            err_irq_q  <= err_irq_d;
            err_addr_q <= err_addr_d;
        end
    end

    assign err_irq  = err_irq_q;
    assign err_addr = err_addr_q;
`else
    assign err_irq  = 1'b0;
    assign err_addr = '0;
`endif

endmodule

// File: tb/tb_ahb_lite_master_bridge.sv
// tb_ahb_lite_master_bridge
//   Directed bench for ahb_lite_master_bridge: a behavioural AHB slave is
//   driven from the single stimulus block, expected completions are queued
//   when a request is issued and popped when mem_ready is seen.
module tb_ahb_lite_master_bridge;

    localparam logic [31:0] ERR_VAL = 32'h0000_0000;

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic        mem_valid;
    logic        mem_instr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [3:0]  HPROT;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic        HRESP;
    logic [31:0] HRDATA;
    logic        err_irq;
    logic [31:0] err_addr;

    ahb_lite_master_bridge #(
        .AW        (32),
        .ERR_RDATA (ERR_VAL)
    ) dut (
        .HCLK      (HCLK),
        .HRESET    (HRESET),
        .mem_valid (mem_valid),
        .mem_instr (mem_instr),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata),
        .HADDR     (HADDR),
        .HTRANS    (HTRANS),
        .HWRITE    (HWRITE),
        .HSIZE     (HSIZE),
        .HBURST    (HBURST),
        .HPROT     (HPROT),
        .HWDATA    (HWDATA),
        .HREADY    (HREADY),
        .HRESP     (HRESP),
        .HRDATA    (HRDATA),
        .err_irq   (err_irq),
        .err_addr  (err_addr)
    );

    always #5 HCLK = ~HCLK;

    typedef struct {
        logic        is_read;
        logic [31:0] rdata;
        int          latency;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    // One complete request. waits = HREADY=0 cycles in the data phase; with
    // err=1 HRESP is held high through those cycles and the completing one.
    task automatic run_xfer(input string tag, input logic [31:0] addr, input logic [3:0] wstrb,
                            input logic [31:0] wdata, input logic instr, input int waits,
                            input logic err, input logic [31:0] rdata, input logic [31:0] exp_haddr,
                            input logic [2:0] exp_hsize, input logic drop_valid);
        exp_t e;
        exp_t got;
        int   cyc;
        e.is_read = (wstrb == 4'b0000);
        e.rdata   = err ? ERR_VAL : rdata;
        e.latency = 3 + waits;
        sb.push_back(e);

        mem_valid = 1'b1; mem_instr = instr; mem_addr = addr;
        mem_wdata = wdata; mem_wstrb = wstrb;
        HREADY = 1'b1; HRESP = 1'b0; HRDATA = rdata;

        tick(); cyc = 1;
        check({tag, ".htrans_a"}, {30'd0, HTRANS}, 32'h2);
        check({tag, ".haddr"}, HADDR, exp_haddr);
        check({tag, ".hsize"}, {29'd0, HSIZE}, {29'd0, exp_hsize});
        check({tag, ".hwrite"}, {31'd0, HWRITE}, {31'd0, (wstrb != 4'b0000)});
        check({tag, ".hprot"}, {28'd0, HPROT}, {28'd0, 2'b00, 1'b1, ~instr});
        check({tag, ".hburst"}, {29'd0, HBURST}, 32'h0);
        if (drop_valid) mem_valid = 1'b0;

        tick(); cyc = 2;
        check({tag, ".htrans_d"}, {30'd0, HTRANS}, 32'h0);
        if (wstrb != 4'b0000) check({tag, ".hwdata"}, HWDATA, wdata);
        for (int i = 0; i < waits; i++) begin
            HREADY = 1'b0; HRESP = err;
            tick(); cyc++;
            check({tag, ".wait_ready"}, {31'd0, mem_ready}, 32'h0);
            check({tag, ".wait_haddr"}, HADDR, exp_haddr);
            check({tag, ".wait_htrans"}, {30'd0, HTRANS}, 32'h0);
        end
        HREADY = 1'b1; HRESP = err;

        do begin
            tick(); cyc++;
        end while (!mem_ready && cyc < 20);
        check({tag, ".ready_seen"}, {31'd0, mem_ready}, 32'h1);
        if (mem_ready) begin
            check({tag, ".sb_nonempty"}, sb.size(), 32'h1);
            if (sb.size() > 0) begin
                got = sb.pop_front();
                check({tag, ".latency"}, cyc, got.latency);
                if (got.is_read) check({tag, ".rdata"}, mem_rdata, got.rdata);
            end
        end
        mem_valid = 1'b0; HRESP = 1'b0;

        tick();
        check({tag, ".ready_pulse"}, {31'd0, mem_ready}, 32'h0);
        check({tag, ".htrans_end"}, {30'd0, HTRANS}, 32'h0);
        tick();
        check({tag, ".no_retrigger"}, {30'd0, HTRANS}, 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "simulation timeout");
    end

    initial begin
        HRESET = 1'b1; mem_valid = 1'b0; mem_instr = 1'b0; mem_addr = '0;
        mem_wdata = '0; mem_wstrb = '0; HREADY = 1'b1; HRESP = 1'b0; HRDATA = '0;
        repeat (3) tick();
        HRESET = 1'b0;
        check("rst.htrans", {30'd0, HTRANS}, 32'h0);
        check("rst.haddr", HADDR, 32'h0);
        check("rst.hwrite", {31'd0, HWRITE}, 32'h0);
        check("rst.hsize", {29'd0, HSIZE}, 32'h2);
        check("rst.hprot", {28'd0, HPROT}, 32'h3);
        check("rst.hwdata", HWDATA, 32'h0);
        check("rst.ready", {31'd0, mem_ready}, 32'h0);
        check("rst.rdata", mem_rdata, 32'h0);
        check("rst.err_irq", {31'd0, err_irq}, 32'h0);
        check("rst.err_addr", err_addr, 32'h0);
        tick();

        run_xfer("rd_word", 32'h0000_1003, 4'b0000, 32'h1111_2222, 1'b0, 0, 1'b0,
                 32'hCAFE_F00D, 32'h0000_1000, 3'b010, 1'b0);
        run_xfer("wr_byte2", 32'h0000_2000, 4'b0100, 32'h00AB_0000, 1'b0, 0, 1'b0,
                 32'h0, 32'h0000_2002, 3'b000, 1'b0);
        run_xfer("wr_byte3", 32'h0000_2001, 4'b1000, 32'hCD00_0000, 1'b0, 0, 1'b0,
                 32'h0, 32'h0000_2003, 3'b000, 1'b1);
        run_xfer("wr_half_hi", 32'h0000_3000, 4'b1100, 32'h5A5A_0000, 1'b0, 0, 1'b0,
                 32'h0, 32'h0000_3002, 3'b001, 1'b0);
        run_xfer("wr_odd_strb", 32'h0000_3004, 4'b0110, 32'h0012_3400, 1'b0, 0, 1'b0,
                 32'h0, 32'h0000_3004, 3'b010, 1'b0);
        run_xfer("rd_wait2", 32'h0000_1100, 4'b0000, 32'h0, 1'b0, 2, 1'b0,
                 32'h1234_5678, 32'h0000_1100, 3'b010, 1'b0);
        run_xfer("ifetch", 32'h0000_0040, 4'b0000, 32'h0, 1'b1, 0, 1'b0,
                 32'h0000_0013, 32'h0000_0040, 3'b010, 1'b0);

        run_xfer("err1", 32'h4000_0000, 4'b0000, 32'h0, 1'b0, 1, 1'b1,
                 32'hDEAD_BEEF, 32'h4000_0000, 3'b010, 1'b0);
`ifdef AHB_MST_ERR_TRAP_EN
        check("err1.irq", {31'd0, err_irq}, 32'h1);
        check("err1.addr", err_addr, 32'h4000_0000);
`else
        check("err1.irq", {31'd0, err_irq}, 32'h0);
        check("err1.addr", err_addr, 32'h0);
`endif
        run_xfer("err2", 32'h5000_0000, 4'b0000, 32'h0, 1'b0, 1, 1'b1,
                 32'hFEED_FACE, 32'h5000_0000, 3'b010, 1'b0);
`ifdef AHB_MST_ERR_TRAP_EN
        check("err2.irq", {31'd0, err_irq}, 32'h1);
        check("err2.addr", err_addr, 32'h4000_0000);
`else
        check("err2.irq", {31'd0, err_irq}, 32'h0);
        check("err2.addr", err_addr, 32'h0);
`endif

        // Reset while a write sits in the data phase with the slave stalling.
        mem_valid = 1'b1; mem_instr = 1'b0; mem_addr = 32'h0000_6000;
        mem_wdata = 32'h9999_8888; mem_wstrb = 4'b1111; HREADY = 1'b1; HRESP = 1'b0;
        tick();
        check("abort.htrans_a", {30'd0, HTRANS}, 32'h2);
        tick();
        check("abort.in_data", {30'd0, HTRANS}, 32'h0);
        HREADY = 1'b0; HRESET = 1'b1;
        tick();
        HRESET = 1'b0; mem_valid = 1'b0; HREADY = 1'b1;
        check("abort.htrans", {30'd0, HTRANS}, 32'h0);
        check("abort.ready", {31'd0, mem_ready}, 32'h0);
        check("abort.haddr", HADDR, 32'h0);
        check("abort.hwrite", {31'd0, HWRITE}, 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("abort.no_ready", {31'd0, mem_ready}, 32'h0);
        end
        run_xfer("post_abort", 32'h0000_7000, 4'b0011, 32'h0000_BEEF, 1'b0, 0, 1'b0,
                 32'h0, 32'h0000_7000, 3'b001, 1'b0);
        check("sb.empty", sb.size(), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ahb_lite_master_bridge.md
Name: ahb_lite_master_bridge

Overview:
- AHB-Lite initiator that converts the PicoRV32 native memory interface (mem_valid/mem_ready) into single, non-burst AHB-Lite transfers.
- Sits between the CPU core and the SoC bus fabric. It drives HADDR/HTRANS/HWRITE/HSIZE/HWDATA to the decoder and slaves, and consumes the HREADY/HRESP/HRDATA returned by the slave response mux.
- Exactly one transfer is outstanding at a time. Outputs are registered.

Parameters:
- AW, 32, address width. HADDR and mem_addr are this wide.
- ERR_RDATA, 32'h0000_0000, value returned on mem_rdata for a read that completes with HRESP=ERROR.

Ports:
- HCLK  in  1  clock.
- HRESET  in  1  synchronous reset, active high.
- mem_valid  in  1  CPU request valid.
- mem_instr  in  1  request is an instruction fetch.
- mem_addr  in  AW  byte address; bits [1:0] are ignored for word accesses.
- mem_wdata  in  32  write data, already lane-replicated by the CPU.
- mem_wstrb  in  4  byte strobes; 0000 means read.
- mem_ready  out  1  one-cycle completion pulse.
- mem_rdata  out  32  read data, valid while mem_ready=1.
- HADDR  out  AW  AHB address.
- HTRANS  out  2  IDLE=00, NONSEQ=10 only.
- HWRITE  out  1  write transfer.
- HSIZE  out  3  000 byte, 001 half, 010 word.
- HBURST  out  3  constant 000 (SINGLE).
- HPROT  out  4  {2'b00, 1'b1, ~mem_instr}.
- HWDATA  out  32  write data, driven in the data phase.
- HREADY  in  1  bus ready from the slave mux.
- HRESP  in  1  0 OKAY, 1 ERROR.
- HRDATA  in  32  read data from the slave mux.
- err_irq  out  1  sticky bus-error flag (optional feature).
- err_addr  out  AW  address of the first errored transfer (optional feature).

Behaviour:
- Reset values (sync, HRESET=1 at a posedge): state=IDLE, HTRANS=00, HADDR=0, HWRITE=0, HSIZE=010, HPROT=0011, HWDATA=0, mem_ready=0, mem_rdata=0, err_irq=0, err_addr=0.
- Reset asserted mid-transfer aborts immediately. The bus sees HTRANS=IDLE from the next cycle and no mem_ready is issued.
- FSM states:
  - IDLE: on mem_valid=1 && mem_ready=0, register HADDR/HWRITE/HSIZE/HPROT, set HTRANS=NONSEQ, go to ADDR.
  - ADDR: hold all address-phase signals stable while HREADY=0. On HREADY=1, set HTRANS=IDLE, drive HWDATA=mem_wdata, go to DATA.
  - DATA: wait for HREADY=1. Then capture HRDATA (or ERR_RDATA if HRESP=1) into mem_rdata, set mem_ready=1, go to DONE.
  - DONE: mem_ready=1 for exactly this cycle; next state is IDLE.
- mem_valid is sampled only in IDLE. Its deassertion mid-transfer is ignored and the transfer completes.
- Minimum latency with a zero-wait slave: mem_valid sampled at edge E0; NONSEQ visible E0..E1; data phase E1..E2; mem_ready high E2..E3. Each HREADY=0 cycle adds one cycle.
- Write size and address mapping from mem_wstrb:
  - 1111: word, HADDR[1:0]=00.
  - 0011: half, offset 00. 1100: half, offset 10.
  - 0001/0010/0100/1000: byte, offset 00/01/10/11.
  - Any other nonzero pattern: word at offset 00.
- Reads are always word, HADDR[1:0]=00.
- ERROR response: HRESP=1 with HREADY=0 is held in DATA. Completion happens on the HRESP=1 && HREADY=1 cycle. No retry and no cancellation of a following transfer, since there is never one pipelined.
- mem_ready never asserts twice for one request. The bridge returns to IDLE for at least one cycle between transfers, so back-to-back requests take 4 cycles each minimum.

Optional Feature:
- Macro AHB_MST_ERR_TRAP_EN.
- When defined:
  - On an errored completion with err_irq=0, set err_irq=1 and latch err_addr=HADDR of that transfer.
  - Later errors do not overwrite err_addr.
  - err_irq clears only on HRESET.
- When undefined: err_irq and err_addr are tied to 0 and errors are reported only via mem_rdata=ERR_RDATA.

Test Plan:
- Word read, zero-wait slave with HRDATA=32'hCAFE_F00D at mem_addr=32'h1000 -> NONSEQ with HADDR=32'h1000, HSIZE=010, HWRITE=0; mem_ready pulses once 3 cycles after mem_valid, with mem_rdata=32'hCAFE_F00D.
- Byte write mem_wstrb=0100, mem_addr=32'h2000, mem_wdata=32'h00AB_0000 -> HADDR=32'h2002, HSIZE=000, HWRITE=1; HWDATA=32'h00AB_0000 in the data phase.
- Slave inserts 2 wait states in the data phase -> HTRANS=IDLE, HADDR held; mem_ready arrives 5 cycles after mem_valid.
- Two-cycle ERROR on a read of 32'h4000_0000 -> mem_rdata=ERR_RDATA, mem_ready one cycle. With AHB_MST_ERR_TRAP_EN: err_irq=1, err_addr=32'h4000_0000. A second error at 32'h5000_0000 leaves err_addr unchanged.
- HRESET asserted during the DATA state of a write -> next cycle HTRANS=00, mem_ready=0, state IDLE; a new request afterwards completes normally.
- Instruction fetch (mem_instr=1) -> HPROT=0010; data read -> HPROT=0011.
